joypad_poller: RTL and testbench

//  Sequences two physical NES controllers (4021 shift-register pads) over shared latch/clock lines.

---
 rtl/joypad_poller.sv | 140 ++++++++++++++
 tb/tb_joypad_poller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_poller.sv
// joypad_poller
//   Polls two NES 4021-style controllers over a shared latch/clock pair and
//   publishes both pads as active-high 8-bit button vectors.
//   A poll is started by the free-running poll timer tick or by a start
//   pulse, but only while enable is high and the sequencer is idle.
// Ports:
//   clk, rst      system clock, async active-high reset
//   enable        allow new polls to start
//   start         one-cycle request for an immediate poll
//   pad_data[1:0] serial data from pad1/pad0, active-low, asynchronous
//   pad_latch     shared latch strobe (registered)
//   pad_clk       shared shift clock, pads shift on rising edge (registered)
//   btns0, btns1  button vectors: 0 A,1 B,2 Select,3 Start,4 Up,5 Down,6 Left,7 Right
//   valid         one-cycle pulse when btns0/btns1 update
//   busy          high while a poll is in progress
module joypad_poller #(
  parameter int LATCH_CYCLES = 256,
  parameter int HALF_BIT     = 128,
  parameter int POLL_PERIOD  = 357955
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] btns0,
  output logic [7:0] btns1,
  output logic       valid,
  output logic       busy
);

  localparam int TW   = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int CMAX = (LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t        state, nxt;
  logic [TW-1:0] tmr;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_cnt;
  logic [1:0]    sync1, sync2;
  logic [7:0]    sr0, sr1;
  logic          tick, req, last;
  logic          latch_d, clk_d, busy_d;

  // Poll timer free-runs from reset, independent of enable and state.
  assign tick = (tmr == TW'(POLL_PERIOD - 1));
  assign req  = (tick | start) & enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tmr <= '0;
    else if (tick) tmr <= '0;
    else           tmr <= tmr + 1'b1;
  end

  // Two-flop synchronizer on the asynchronous pad lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_data;
      sync2 <= sync1;
    end
  end

  // Final cycle of the current timed phase.
  assign last = (state == LATCH) ? (cyc == CW'(LATCH_CYCLES - 1))
                                 : (cyc == CW'(HALF_BIT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req)  nxt = LATCH;
      LATCH: if (last) nxt = LOW;
      LOW:   if (last) nxt = (bit_cnt == 3'd7) ? DONE : HIGH;
      HIGH:  if (last) nxt = LOW;
      DONE:            nxt = IDLE;
      default:         nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the pad lines come straight off flops.
  always_comb begin
    latch_d = (nxt == LATCH);
    clk_d   = (nxt == HIGH);
    busy_d  = (nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      btns0     <= '0;
      btns1     <= '0;
    end else begin
      pad_latch <= latch_d;
      pad_clk   <= clk_d;
      busy      <= busy_d;
      valid     <= (state == DONE);
      if (state == DONE) begin
        btns0 <= ~sr0;
        btns1 <= ~sr1;
      end
    end
  end

  // Phase cycle counter restarts on every state change; bit index and
  // shift registers advance on phase boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     <= '0;
      bit_cnt <= '0;
      sr0     <= '0;
      sr1     <= '0;
    end else begin
      if (nxt != state)        cyc <= '0;
      else if (state != IDLE)  cyc <= cyc + 1'b1;
      if (state == LATCH && last) bit_cnt <= '0;
      if (state == HIGH && last)  bit_cnt <= bit_cnt + 1'b1;
      if (state == LOW && last) begin
        sr0[bit_cnt] <= sync2[0];
        sr1[bit_cnt] <= sync2[1];
      end
    end
  end

endmodule

// File: tb/tb_joypad_poller.sv
module tb_joypad_poller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [1:0] pad_data;
  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] btns0, btns1;

  // 4021 pad models
  logic [7:0] b0 = 8'h00, b1 = 8'h00;
  logic [7:0] m0 = 8'hFF, m1 = 8'hFF;
  logic [1:0] disc = 2'b00;

  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) begin
      m0 = ~b0;
      m1 = ~b1;
    end else begin
      m0 = {1'b1, m0[7:1]};
      m1 = {1'b1, m1[7:1]};
    end
  end

  assign pad_data = {m1[0] | disc[1], m0[0] | disc[0]};

  joypad_poller #(.LATCH_CYCLES(4), .HALF_BIT(3), .POLL_PERIOD(200)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .btns0(btns0), .btns1(btns1),
    .valid(valid), .busy(busy)
  );

  // Leaves rst released at a negedge; the next posedge is edge 1.
  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one start and returns the cycles until valid (capped at 100).
  task automatic poll_once(output int lat);
    enable = 1'b1; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!valid && lat < 100);
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pad_latch, pad_clk, valid, busy, btns0, btns1} !== 20'h0)
      $display("FAIL reset_outputs got %h want 0", {pad_latch, pad_clk, valid, busy, btns0, btns1});
    else passes++;
    start = 1'b0; enable = 1'b0;
  endtask

  task automatic test_single_poll();
    reset_dut();
    b0 = 8'h09; b1 = 8'h80; enable = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      logic el, ec, ev, eb;
      start = (i == 1);
      @(negedge clk);
      el = (i <= 4);
      ec = (i >= 8) && (i <= 46) && (((i - 8) % 6) < 3);
      ev = (i == 51);
      eb = (i <= 50);
      checks++;
      if (pad_latch !== el) $display("FAIL t1_latch i=%0d got %b want %b", i, pad_latch, el);
      else passes++;
      checks++;
      if (pad_clk !== ec) $display("FAIL t1_padclk i=%0d got %b want %b", i, pad_clk, ec);
      else passes++;
      checks++;
      if (valid !== ev) $display("FAIL t1_valid i=%0d got %b want %b", i, valid, ev);
      else passes++;
      checks++;
      if (busy !== eb) $display("FAIL t1_busy i=%0d got %b want %b", i, busy, eb);
      else passes++;
    end
    enable = 1'b0;
    checks++;
    if (btns0 !== 8'h09) $display("FAIL t1_btns0 got %h want 09", btns0);
    else passes++;
    checks++;
    if (btns1 !== 8'h80) $display("FAIL t1_btns1 got %h want 80", btns1);
    else passes++;
  endtask

  task automatic test_periodic();
    logic [7:0] p0 [3] = '{8'h01, 8'h10, 8'hFF};
    logic [7:0] p1 [3] = '{8'h02, 8'h40, 8'h00};
    reset_dut();
    b0 = p0[0]; b1 = p1[0]; enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      int n, en;
      n = 0;
      en = (p == 0) ? 250 : 200;
      do begin
        @(negedge clk);
        n++;
      end while (!valid && n < 300);
      checks++;
      if (n !== en) $display("FAIL t2_interval p=%0d got %0d want %0d", p, n, en);
      else passes++;
      checks++;
      if ({btns0, btns1} !== {p0[p], p1[p]})
        $display("FAIL t2_btns p=%0d got %h want %h", p, {btns0, btns1}, {p0[p], p1[p]});
      else passes++;
      if (p < 2) begin
        b0 = p0[p+1]; b1 = p1[p+1];
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    b0 = 8'h42; b1 = 8'h24; enable = 1'b1;
    for (int i = 1; i <= 399; i++) begin
      logic ev, el;
      start = (i == 10) || (i == 20) || (i == 30) || (i == 55) || (i == 60) ||
              (i == 200) || (i == 210) || (i == 250);
      @(negedge clk);
      ev = (i == 60) || (i == 250);
      el = ((i >= 10) && (i <= 13)) || ((i >= 200) && (i <= 203));
      checks++;
      if (valid !== ev) $display("FAIL t3_valid i=%0d got %b want %b", i, valid, ev);
      else passes++;
      checks++;
      if (pad_latch !== el) $display("FAIL t3_latch i=%0d got %b want %b", i, pad_latch, el);
      else passes++;
    end
    start = 1'b0; enable = 1'b0;
    checks++;
    if ({btns0, btns1} !== 16'h4224) $display("FAIL t3_btns got %h want 4224", {btns0, btns1});
    else passes++;
  endtask

  task automatic test_enable();
    reset_dut();
    b0 = 8'h11; b1 = 8'h22;
    for (int i = 1; i <= 500; i++) begin
      logic ev, eb;
      enable = (i == 251);
      start  = ((i % 50) == 7) || (i == 251);
      @(negedge clk);
      ev = (i == 301);
      eb = (i >= 251) && (i <= 300);
      checks++;
      if ({valid, busy} !== {ev, eb})
        $display("FAIL t4_valid_busy i=%0d got %b%b want %b%b", i, valid, busy, ev, eb);
      else passes++;
      if (i == 250) begin
        checks++;
        if ({btns0, btns1} !== 16'h0000) $display("FAIL t4_btns_idle got %h want 0000", {btns0, btns1});
        else passes++;
      end
    end
    start = 1'b0; enable = 1'b0;
    checks++;
    if ({btns0, btns1} !== 16'h1122) $display("FAIL t4_btns got %h want 1122", {btns0, btns1});
    else passes++;
  endtask

  task automatic test_reset_midpoll();
    int lat;
    reset_dut();
    b0 = 8'h0F; b1 = 8'hF0; enable = 1'b1;
    for (int i = 1; i <= 92; i++) begin
      start = (i == 1) || (i == 60);
      if (i == 55) begin b0 = 8'h33; b1 = 8'hCC; end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if ({pad_clk, busy, btns0, btns1} !== {2'b11, 16'h0FF0})
      $display("FAIL t5_pre got %b%b %h want 11 0ff0", pad_clk, busy, {btns0, btns1});
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({pad_latch, pad_clk, valid, busy, btns0, btns1} !== 20'h0)
      $display("FAIL t5_async_rst got %h want 0", {pad_latch, pad_clk, valid, busy, btns0, btns1});
    else passes++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b0 = 8'h81; b1 = 8'h18;
    poll_once(lat);
    checks++;
    if (lat !== 51) $display("FAIL t5_latency got %0d want 51", lat);
    else passes++;
    checks++;
    if ({btns0, btns1} !== 16'h8118) $display("FAIL t5_btns got %h want 8118", {btns0, btns1});
    else passes++;
  endtask

  task automatic test_patterns();
    logic [7:0] v0 [3] = '{8'hFF, 8'h55, 8'h01};
    logic [7:0] v1 [3] = '{8'hFF, 8'hAA, 8'h80};
    logic [7:0] e0 [3] = '{8'h00, 8'h55, 8'h01};
    logic [7:0] e1 [3] = '{8'h00, 8'hAA, 8'h80};
    for (int k = 0; k < 3; k++) begin
      int lat;
      reset_dut();
      disc = (k == 0) ? 2'b11 : 2'b00;
      b0 = v0[k]; b1 = v1[k];
      poll_once(lat);
      checks++;
      if (lat !== 51) $display("FAIL t6_latency k=%0d got %0d want 51", k, lat);
      else passes++;
      checks++;
      if ({btns0, btns1} !== {e0[k], e1[k]})
        $display("FAIL t6_btns k=%0d got %h want %h", k, {btns0, btns1}, {e0[k], e1[k]});
      else passes++;
    end
    disc = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_poll();
    test_periodic();
    test_back_to_back();
    test_enable();
    test_reset_midpoll();
    test_patterns();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
